// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the memory stage: FSM states, width defaults
// and the packed MEM/WB payload that the writeback mux consumes.
package mem_stage_pkg;

   localparam int DATA_W_DEF  = 16;
   localparam int REG_AW_DEF  = 3;
   localparam int TIMEOUT_DEF = 63;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   typedef struct packed {
      logic [DATA_W_DEF-1:0] readData;
      logic [DATA_W_DEF-1:0] aluOutput;
      logic [DATA_W_DEF-1:0] PC_Next;
      logic                  memToReg;
      logic                  JAL_en;
      logic                  regWrite;
      logic [REG_AW_DEF-1:0] writeReg;
      logic                  valid;
   } memWb_t;

endpackage

// File: rtl/mem_stage_ctrl_mem_wb_reg.sv
// MEM/WB boundary register: loads a full payload, or squashes the held one
// into a bubble so writeback sees neither a valid instruction nor a write.
module mem_wb_reg
   import mem_stage_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   i_load,
   input  logic   i_bubble,
   input  memWb_t i_data,
   output memWb_t o_data
);

   memWb_t r_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data <= '0;
      end else if (i_load) begin
         r_data <= i_data;
      end else if (i_bubble) begin
         r_data.valid    <= 1'b0;
         r_data.regWrite <= 1'b0;
      end
   end

   assign o_data = r_data;

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory stage controller: issues req/ack accesses, stalls upstream while waiting,
// and feeds the MEM/WB register. Optional macro MEM_ALIGN_CHECK_EN rejects odd addresses.
module mem_stage_ctrl
   import mem_stage_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int REG_AW  = REG_AW_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_valid,
   input  logic [DATA_W-1:0] ex_aluOutput,
   input  logic [DATA_W-1:0] ex_storeData,
   input  logic [DATA_W-1:0] ex_PC_Next,
   input  logic              ex_memRead,
   input  logic              ex_memWrite,
   input  logic              ex_memToReg,
   input  logic              ex_JAL_en,
   input  logic              ex_regWrite,
   input  logic [REG_AW-1:0] ex_writeReg,
   output logic              mem_req,
   output logic              mem_wr,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall,
   output logic              wb_valid,
   output logic [DATA_W-1:0] wb_readData,
   output logic [DATA_W-1:0] wb_aluOutput,
   output logic [DATA_W-1:0] wb_PC_Next,
   output logic              wb_memToReg,
   output logic              wb_JAL_en,
   output logic              wb_regWrite,
   output logic [REG_AW-1:0] wb_writeReg,
   output logic              err
);

   localparam int            CW     = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] C_MAX  = CW'(TIMEOUT);

   state_t        r_state;
   state_t        w_nextState;
   logic [CW-1:0] r_count;
   memWb_t        r_hold;
   logic          r_isLoad;
   logic          r_err;

   logic   w_memop;
   logic   w_illegal;
   logic   w_issue;
   logic   w_errSet;
   logic   w_wbLoad;
   logic   w_wbBubble;
   memWb_t w_exPayload;
   memWb_t w_wbIn;
   memWb_t w_wbOut;

   assign w_memop = ex_memRead | ex_memWrite;

`ifdef MEM_ALIGN_CHECK_EN
   assign w_illegal = (ex_memRead & ex_memWrite) | (w_memop & ex_aluOutput[0]);
`else
   assign w_illegal = ex_memRead & ex_memWrite;
`endif

   assign mem_addr  = ex_aluOutput;
   assign mem_wdata = ex_storeData;
   assign mem_wr    = ex_memWrite;

   always_comb begin
      w_exPayload           = '0;
      w_exPayload.aluOutput = ex_aluOutput;
      w_exPayload.PC_Next   = ex_PC_Next;
      w_exPayload.memToReg  = ex_memToReg;
      w_exPayload.JAL_en    = ex_JAL_en;
      w_exPayload.regWrite  = ex_regWrite;
      w_exPayload.writeReg  = ex_writeReg;
      w_exPayload.valid     = 1'b1;
   end

   // Every cycle either loads MEM/WB or bubbles it, so nothing can retire twice.
   always_comb begin
      w_nextState = r_state;
      mem_req     = 1'b0;
      stall       = 1'b0;
      w_issue     = 1'b0;
      w_errSet    = 1'b0;
      w_wbLoad    = 1'b0;
      w_wbBubble  = 1'b1;
      w_wbIn      = w_exPayload;
      case (r_state)
         IDLE: begin
            if (ex_valid) begin
               if (w_illegal) begin
                  w_errSet = 1'b1;
               end else if (w_memop) begin
                  mem_req     = 1'b1;
                  stall       = 1'b1;
                  w_issue     = 1'b1;
                  w_nextState = WAIT;
               end else begin
                  w_wbLoad   = 1'b1;
                  w_wbBubble = 1'b0;
               end
            end
         end
         WAIT: begin
            stall = ~mem_ack;
            if (mem_ack) begin
               w_wbLoad        = 1'b1;
               w_wbBubble      = 1'b0;
               w_wbIn          = r_hold;
               w_wbIn.readData = r_isLoad ? mem_rdata : '0;
               w_wbIn.valid    = 1'b1;
               w_nextState     = IDLE;
            end else if (r_count == C_LAST) begin
               w_errSet    = 1'b1;
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_count  <= '0;
         r_hold   <= '0;
         r_isLoad <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state <= w_nextState;
         r_err   <= r_err | w_errSet;
         if (w_issue) begin
            r_hold   <= w_exPayload;
            r_isLoad <= ex_memRead;
            r_count  <= '0;
         end else if (r_state == WAIT) begin
            if (mem_ack) begin
               r_count <= '0;
            end else if (r_count != C_MAX) begin
               r_count <= r_count + 1'b1;
            end
         end
      end
   end

   mem_wb_reg u_memWbReg (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_load   (w_wbLoad),
      .i_bubble (w_wbBubble),
      .i_data   (w_wbIn),
      .o_data   (w_wbOut)
   );

   assign wb_valid     = w_wbOut.valid;
   assign wb_readData  = w_wbOut.readData;
   assign wb_aluOutput = w_wbOut.aluOutput;
   assign wb_PC_Next   = w_wbOut.PC_Next;
   assign wb_memToReg  = w_wbOut.memToReg;
   assign wb_JAL_en    = w_wbOut.JAL_en;
   assign wb_regWrite  = w_wbOut.regWrite;
   assign wb_writeReg  = w_wbOut.writeReg;
   assign err          = r_err;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed instruction sequences checked
// every cycle against a transaction-level model, plus hand-computed pins.
module tb_mem_stage_ctrl;

   localparam int TIMEOUT = 63;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid;
   logic [15:0] ex_aluOutput;
   logic [15:0] ex_storeData;
   logic [15:0] ex_PC_Next;
   logic        ex_memRead;
   logic        ex_memWrite;
   logic        ex_memToReg;
   logic        ex_JAL_en;
   logic        ex_regWrite;
   logic [2:0]  ex_writeReg;
   logic        mem_req;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic        stall;
   logic        wb_valid;
   logic [15:0] wb_readData;
   logic [15:0] wb_aluOutput;
   logic [15:0] wb_PC_Next;
   logic        wb_memToReg;
   logic        wb_JAL_en;
   logic        wb_regWrite;
   logic [2:0]  wb_writeReg;
   logic        err;

   mem_stage_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ex_valid     (ex_valid),
      .ex_aluOutput (ex_aluOutput),
      .ex_storeData (ex_storeData),
      .ex_PC_Next   (ex_PC_Next),
      .ex_memRead   (ex_memRead),
      .ex_memWrite  (ex_memWrite),
      .ex_memToReg  (ex_memToReg),
      .ex_JAL_en    (ex_JAL_en),
      .ex_regWrite  (ex_regWrite),
      .ex_writeReg  (ex_writeReg),
      .mem_req      (mem_req),
      .mem_wr       (mem_wr),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_ack      (mem_ack),
      .mem_rdata    (mem_rdata),
      .stall        (stall),
      .wb_valid     (wb_valid),
      .wb_readData  (wb_readData),
      .wb_aluOutput (wb_aluOutput),
      .wb_PC_Next   (wb_PC_Next),
      .wb_memToReg  (wb_memToReg),
      .wb_JAL_en    (wb_JAL_en),
      .wb_regWrite  (wb_regWrite),
      .wb_writeReg  (wb_writeReg),
      .err          (err)
   );

   always #5 clk = ~clk;

   int checks    = 0;
   int failures  = 0;
   int stallSeen = 0;
   int reqSeen   = 0;
   int wbSeen    = 0;

   // Model: one outstanding access (pend*) plus the MEM/WB contents expected after the next edge.
   bit          pend;
   int          pendWait;
   bit          pendLoad;
   logic [15:0] hAlu, hPc;
   logic        hM2R, hJal, hRw;
   logic [2:0]  hWr;
   logic        eValid, eM2R, eJal, eRw, eErr;
   logic [15:0] eRead, eAlu, ePc;
   logic [2:0]  eWr;

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit isIllegal();
`ifdef MEM_ALIGN_CHECK_EN
      return (ex_memRead && ex_memWrite) || ((ex_memRead || ex_memWrite) && ex_aluOutput[0]);
`else
      return ex_memRead && ex_memWrite;
`endif
   endfunction

   task automatic modelReset();
      pend = 0; pendWait = 0; pendLoad = 0;
      hAlu = '0; hPc = '0; hM2R = 0; hJal = 0; hRw = 0; hWr = '0;
      eValid = 0; eRead = '0; eAlu = '0; ePc = '0; eM2R = 0; eJal = 0; eRw = 0; eWr = '0;
      eErr = 0;
   endtask

   task automatic modelBubble();
      eValid = 0;
      eRw    = 0;
   endtask

   task automatic modelStep();
      if (pend) begin
         if (mem_ack) begin
            eValid = 1; eRead = pendLoad ? mem_rdata : 16'h0;
            eAlu = hAlu; ePc = hPc; eM2R = hM2R; eJal = hJal; eRw = hRw; eWr = hWr;
            pend = 0;
         end else begin
            pendWait++;
            modelBubble();
            if (pendWait == TIMEOUT) begin
               pend = 0;
               eErr = 1;
            end
         end
      end else if (ex_valid) begin
         if (isIllegal()) begin
            eErr = 1;
            modelBubble();
         end else if (ex_memRead || ex_memWrite) begin
            pend = 1; pendWait = 0; pendLoad = ex_memRead;
            hAlu = ex_aluOutput; hPc = ex_PC_Next; hM2R = ex_memToReg;
            hJal = ex_JAL_en; hRw = ex_regWrite; hWr = ex_writeReg;
            modelBubble();
         end else begin
            eValid = 1; eRead = 16'h0; eAlu = ex_aluOutput; ePc = ex_PC_Next;
            eM2R = ex_memToReg; eJal = ex_JAL_en; eRw = ex_regWrite; eWr = ex_writeReg;
         end
      end else begin
         modelBubble();
      end
   endtask

   // Per-cycle comparison of every meaningful DUT output against the model.
   task automatic compareModel();
      logic expReq, expStall;
      if (!rst_n) modelReset();
      expReq   = !pend && ex_valid && (ex_memRead || ex_memWrite) && !isIllegal();
      expStall = pend ? !mem_ack : expReq;
      checkOutput("mem_req", 16'(mem_req), 16'(expReq));
      checkOutput("stall", 16'(stall), 16'(expStall));
      checkOutput("err", 16'(err), 16'(eErr));
      checkOutput("wb_valid", 16'(wb_valid), 16'(eValid));
      checkOutput("wb_regWrite", 16'(wb_regWrite), 16'(eRw));
      if (expReq) begin
         checkOutput("mem_addr", mem_addr, ex_aluOutput);
         checkOutput("mem_wdata", mem_wdata, ex_storeData);
         checkOutput("mem_wr", 16'(mem_wr), 16'(ex_memWrite));
      end
      if (eValid) begin
         checkOutput("wb_readData", wb_readData, eRead);
         checkOutput("wb_aluOutput", wb_aluOutput, eAlu);
         checkOutput("wb_PC_Next", wb_PC_Next, ePc);
         checkOutput("wb_memToReg", 16'(wb_memToReg), 16'(eM2R));
         checkOutput("wb_JAL_en", 16'(wb_JAL_en), 16'(eJal));
         checkOutput("wb_writeReg", 16'(wb_writeReg), 16'(eWr));
      end
      if (stall)    stallSeen++;
      if (mem_req)  reqSeen++;
      if (wb_valid) wbSeen++;
      if (rst_n) modelStep();
   endtask

   task automatic setIdle();
      ex_valid = 0; ex_aluOutput = '0; ex_storeData = '0; ex_PC_Next = '0;
      ex_memRead = 0; ex_memWrite = 0; ex_memToReg = 0; ex_JAL_en = 0;
      ex_regWrite = 0; ex_writeReg = '0;
   endtask

   task automatic applyStimulus(input logic rd, input logic wr, input logic [15:0] alu,
                                input logic [15:0] sd, input logic [15:0] pc, input logic m2r,
                                input logic jal, input logic rw, input logic [2:0] wreg);
      ex_valid = 1; ex_memRead = rd; ex_memWrite = wr; ex_aluOutput = alu;
      ex_storeData = sd; ex_PC_Next = pc; ex_memToReg = m2r; ex_JAL_en = jal;
      ex_regWrite = rw; ex_writeReg = wreg;
   endtask

   task automatic settle();
      @(negedge clk);
      compareModel();
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   task automatic step();
      settle();
      advance();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int s0, r0, v0;
      rst_n = 0; mem_ack = 0; mem_rdata = '0;
      setIdle();
      settle();
      checkOutput("reset_wb_valid", 16'(wb_valid), 16'd0);
      checkOutput("reset_err", 16'(err), 16'd0);
      checkOutput("reset_stall", 16'(stall), 16'd0);
      advance();
      step();
      rst_n = 1;
      step();

      // Back-to-back ALU ops, second one a JAL link.
      s0 = stallSeen;
      applyStimulus(0, 0, 16'h0042, 16'h0, 16'h0102, 0, 0, 1, 3'd3);
      settle();
      advance();
      applyStimulus(0, 0, 16'h1111, 16'h0, 16'h0104, 0, 1, 1, 3'd7);
      settle();
      checkOutput("alu_wb_valid", 16'(wb_valid), 16'd1);
      checkOutput("alu_wb_aluOutput", wb_aluOutput, 16'h0042);
      checkOutput("alu_wb_writeReg", 16'(wb_writeReg), 16'd3);
      advance();
      setIdle();
      settle();
      checkOutput("jal_wb_PC_Next", wb_PC_Next, 16'h0104);
      checkOutput("jal_wb_JAL_en", 16'(wb_JAL_en), 16'd1);
      advance();
      step();
      checkOutput("alu_stall_cycles", 16'(stallSeen - s0), 16'd0);

      // Load acked 3 cycles after the request.
      s0 = stallSeen; r0 = reqSeen; v0 = wbSeen;
      applyStimulus(1, 0, 16'h0010, 16'h0, 16'h0200, 1, 0, 1, 3'd5);
      settle();
      checkOutput("load_mem_req", 16'(mem_req), 16'd1);
      checkOutput("load_mem_addr", mem_addr, 16'h0010);
      checkOutput("load_mem_wr", 16'(mem_wr), 16'd0);
      advance();
      step();
      step();
      mem_ack = 1; mem_rdata = 16'hBEEF;
      settle();
      checkOutput("load_ack_stall", 16'(stall), 16'd0);
      advance();
      mem_ack = 0; mem_rdata = '0;
      setIdle();
      settle();
      checkOutput("load_wb_valid", 16'(wb_valid), 16'd1);
      checkOutput("load_wb_readData", wb_readData, 16'hBEEF);
      advance();
      step();
      step();
      checkOutput("load_stall_cycles", 16'(stallSeen - s0), 16'd3);
      checkOutput("load_req_pulses", 16'(reqSeen - r0), 16'd1);
      checkOutput("load_wb_count", 16'(wbSeen - v0), 16'd1);

      // Store acked 1 cycle after the request; read data must not leak into WB.
      applyStimulus(0, 1, 16'h0020, 16'h1234, 16'h0300, 0, 0, 0, 3'd2);
      settle();
      checkOutput("store_mem_wr", 16'(mem_wr), 16'd1);
      checkOutput("store_mem_wdata", mem_wdata, 16'h1234);
      advance();
      mem_ack = 1; mem_rdata = 16'hFFFF;
      step();
      mem_ack = 0; mem_rdata = '0;
      setIdle();
      settle();
      checkOutput("store_wb_valid", 16'(wb_valid), 16'd1);
      checkOutput("store_wb_readData", wb_readData, 16'h0000);
      checkOutput("store_wb_regWrite", 16'(wb_regWrite), 16'd0);
      advance();

      // Load that never gets acked in time, then a late ack at cycle 70.
      s0 = stallSeen; r0 = reqSeen; v0 = wbSeen;
      applyStimulus(1, 0, 16'h0030, 16'h0, 16'h0400, 1, 0, 1, 3'd4);
      settle();
      advance();
      for (int i = 1; i <= 70; i++) begin
         if (i == 64) setIdle();
         if (i == 70) begin
            mem_ack = 1; mem_rdata = 16'hDEAD;
         end
         settle();
         if (i == 63) begin
            checkOutput("timeout_err_before", 16'(err), 16'd0);
            checkOutput("timeout_stall_last", 16'(stall), 16'd1);
         end
         if (i == 64) begin
            checkOutput("timeout_err", 16'(err), 16'd1);
            checkOutput("timeout_stall_drop", 16'(stall), 16'd0);
         end
         advance();
      end
      mem_ack = 0; mem_rdata = '0;
      step();
      checkOutput("timeout_stall_cycles", 16'(stallSeen - s0), 16'd64);
      checkOutput("timeout_req_pulses", 16'(reqSeen - r0), 16'd1);
      checkOutput("timeout_wb_count", 16'(wbSeen - v0), 16'd0);

      // Reset in the middle of WAIT, then an ALU op and a stray ack in IDLE.
      applyStimulus(1, 0, 16'h0040, 16'h0, 16'h0500, 1, 0, 1, 3'd1);
      step();
      step();
      rst_n = 0;
      setIdle();
      settle();
      checkOutput("rst_stall", 16'(stall), 16'd0);
      checkOutput("rst_mem_req", 16'(mem_req), 16'd0);
      checkOutput("rst_err", 16'(err), 16'd0);
      checkOutput("rst_wb_aluOutput", wb_aluOutput, 16'h0000);
      advance();
      step();
      rst_n = 1;
      applyStimulus(0, 0, 16'h0077, 16'h0, 16'h0600, 0, 0, 1, 3'd6);
      settle();
      advance();
      setIdle();
      mem_ack = 1; mem_rdata = 16'h5555;
      settle();
      checkOutput("postrst_wb_valid", 16'(wb_valid), 16'd1);
      checkOutput("postrst_wb_aluOutput", wb_aluOutput, 16'h0077);
      advance();
      mem_ack = 0; mem_rdata = '0;
      settle();
      checkOutput("stray_ack_wb_valid", 16'(wb_valid), 16'd0);
      advance();

      // Both read and write set: rejected without touching memory.
      applyStimulus(1, 1, 16'h0050, 16'hAAAA, 16'h0700, 0, 0, 1, 3'd3);
      settle();
      checkOutput("illegal_mem_req", 16'(mem_req), 16'd0);
      checkOutput("illegal_stall", 16'(stall), 16'd0);
      advance();
      setIdle();
      settle();
      checkOutput("illegal_err", 16'(err), 16'd1);
      checkOutput("illegal_wb_valid", 16'(wb_valid), 16'd0);
      advance();

      // Odd-address load.
      rst_n = 0;
      step();
      rst_n = 1;
      applyStimulus(1, 0, 16'h0011, 16'h0, 16'h0800, 1, 0, 1, 3'd2);
      settle();
`ifdef MEM_ALIGN_CHECK_EN
      checkOutput("align_mem_req", 16'(mem_req), 16'd0);
      advance();
      setIdle();
      settle();
      checkOutput("align_err", 16'(err), 16'd1);
      checkOutput("align_wb_valid", 16'(wb_valid), 16'd0);
      advance();
`else
      checkOutput("odd_mem_req", 16'(mem_req), 16'd1);
      checkOutput("odd_mem_addr", mem_addr, 16'h0011);
      advance();
      mem_ack = 1; mem_rdata = 16'h5A5A;
      step();
      mem_ack = 0; mem_rdata = '0;
      setIdle();
      settle();
      checkOutput("odd_wb_readData", wb_readData, 16'h5A5A);
      checkOutput("odd_err", 16'(err), 16'd0);
      advance();
`endif
      step();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory stage of the 16-bit pipelined core; sits directly upstream of the writeback mux.
- Takes EX results and drives a multi-cycle data memory through a req/ack handshake.
- Stalls upstream while an access is outstanding.
- Registers readData, aluOutput, PC_Next and the writeback controls (memToReg, JAL_en, regWrite, writeReg) into the MEM/WB boundary that writeback consumes.

Parameters:
- DATA_W, 16, datapath and memory data width.
- REG_AW, 3, register-file address width.
- TIMEOUT, 63, maximum cycles in WAIT before an access is aborted.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  EX holds a valid instruction.
- ex_aluOutput  in  DATA_W  ALU result; also the memory address.
- ex_storeData  in  DATA_W  store data.
- ex_PC_Next  in  DATA_W  PC+2, used for JAL link.
- ex_memRead  in  1  load.
- ex_memWrite  in  1  store.
- ex_memToReg  in  1  writeback select, forwarded.
- ex_JAL_en  in  1  writeback select, forwarded.
- ex_regWrite  in  1  register write enable.
- ex_writeReg  in  REG_AW  destination register.
- mem_req  out  1  one-cycle access request pulse.
- mem_wr  out  1  1 = write, 0 = read; valid with mem_req.
- mem_addr  out  DATA_W  access address.
- mem_wdata  out  DATA_W  write data.
- mem_ack  in  1  access complete; mem_rdata valid this cycle.
- mem_rdata  in  DATA_W  read data.
- stall  out  1  freeze EX and upstream stages.
- wb_valid  out  1  MEM/WB holds a valid instruction.
- wb_readData  out  DATA_W  load data.
- wb_aluOutput  out  DATA_W  ALU result.
- wb_PC_Next  out  DATA_W  link value.
- wb_memToReg  out  1  forwarded writeback select.
- wb_JAL_en  out  1  forwarded writeback select.
- wb_regWrite  out  1  forwarded write enable.
- wb_writeReg  out  REG_AW  forwarded destination register.
- err  out  1  sticky memory error flag.

Behaviour:
- Reset (rst_n low, async): state=IDLE, timeout counter=0, every registered output=0, err=0. mem_req=0 and stall=0 because the FSM is in IDLE.
- memop = ex_memRead | ex_memWrite.
- IDLE, ex_valid & !memop:
  - MEM/WB loads the EX fields next edge; wb_readData=0; wb_valid=1.
  - Latency EX->WB is 1 cycle; stall=0.
- IDLE, ex_valid & memop:
  - Drive mem_req=1 combinationally: mem_addr=ex_aluOutput, mem_wdata=ex_storeData, mem_wr=ex_memWrite.
  - Latch EX fields into an internal holding register; go to WAIT.
  - stall=1; MEM/WB takes a bubble (wb_valid=0, wb_regWrite=0).
- WAIT:
  - mem_req=0; counter increments each cycle.
  - stall = !mem_ack, so upstream advances in the same cycle the ack arrives.
  - On mem_ack: MEM/WB loads the held fields, plus mem_rdata into wb_readData when the op was a load (0 for a store). wb_valid=1 next edge; counter clears; go to IDLE.
  - Memory-op latency = ack cycle + 1.
- Timeout: counter reaches TIMEOUT with no ack -> err=1, go to IDLE, stall drops, bubble into MEM/WB (the aborted instruction never writes back).
- Illegal op (ex_memRead & ex_memWrite both 1 in IDLE): no mem_req, err=1, bubble, stall=0.
- mem_ack while in IDLE: ignored. This covers a late ack after a timeout or after reset.
- Reset mid-WAIT: returns to IDLE immediately; the outstanding access is abandoned.
- ex_valid=0 in IDLE: bubble; mem_req=0.
- err is sticky; cleared only by reset.
- No arithmetic in the block beyond the counter, which saturates at TIMEOUT.

Optional Feature:
- MEM_ALIGN_CHECK_EN defined: a memop with ex_aluOutput[0]=1 is treated as illegal — no mem_req, err=1, bubble, stall=0.
- MEM_ALIGN_CHECK_EN undefined: the address is passed to memory unmodified; no alignment check logic is present.

Decomposition:
- Package mem_stage_pkg holds:
  - state enum {IDLE, WAIT};
  - DATA_W and REG_AW defaults;
  - TIMEOUT default;
  - a packed struct for the MEM/WB payload (readData, aluOutput, PC_Next, memToReg, JAL_en, regWrite, writeReg, valid).
- One natural sub-module: mem_wb_reg, a payload register with async active-low reset, load enable and bubble insert.

Test Plan:
- Non-memory op: ALU op with ex_aluOutput=16'h0042, regWrite=1, writeReg=3 -> next cycle wb_valid=1, wb_aluOutput=16'h0042, wb_writeReg=3, stall never asserted.
- Load: addr=16'h0010, memory acks 3 cycles after req with 16'hBEEF -> mem_req pulses 1 cycle; stall high 3 cycles; wb_readData=16'hBEEF and wb_valid=1 the cycle after ack; exactly one wb_valid.
- Store: addr=16'h0020, storeData=16'h1234, ack after 1 cycle -> mem_wr=1, mem_wdata=16'h1234; wb_readData=0; wb_regWrite follows ex_regWrite=0.
- Timeout: load with no ack for 63 cycles -> err=1, stall drops, wb_valid stays 0; a late ack at cycle 70 has no effect.
- Reset mid-WAIT: rst_n low 2 cycles during WAIT -> all outputs 0, state IDLE; a following ALU op completes in 1 cycle.
- Illegal op: memRead=memWrite=1 -> no mem_req, err=1, bubble. With MEM_ALIGN_CHECK_EN defined, a load at 16'h0011 gives the same result.
